// File: rtl/pe2_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : pe2_controller                                               |
// | Purpose : Job sequencer for PE2 - kernel load, tap stepping, OFM pack. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pe2_controller #(
    parameter int TAPS           = 16,
    parameter int LANES_PER_WORD = 4,
    parameter int ADDR_W         = 32,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_windows,
    input  logic [ADDR_W-1:0] ofm_base,
    input  logic              filter_valid,
    output logic              filter_ready,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [TAPS-1:0]   kernelFilter_en,
    output logic [3:0]        mux_sel,
    output logic              mac_en,
    output logic              mac_rst,
    output logic              shiftReg_en,
    output logic              counter_rst,
    output logic              counter_en,
    output logic              ofm_we,
    output logic [ADDR_W-1:0] ofm_addr,
    output logic [31:0]       number,
    output logic              done,
    output logic              busy
);

    localparam int c_LANE_W = $clog2(LANES_PER_WORD + 1);
    localparam int c_WORDS  = TAPS / 4;
    localparam int c_K_W    = $clog2(c_WORDS);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_LOAD  = 3'd1;
    localparam logic [2:0] c_S_CLEAR = 3'd2;
    localparam logic [2:0] c_S_MAC   = 3'd3;
    localparam logic [2:0] c_S_SHIFT = 3'd4;
    localparam logic [2:0] c_S_WRITE = 3'd5;
    localparam logic [2:0] c_S_DONE  = 3'd6;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [c_K_W-1:0]    r_k;
    logic [3:0]          r_tap;
    logic [c_LANE_W-1:0] r_lane;
    logic [CNT_W-1:0]    r_num;
    logic [CNT_W-1:0]    r_win;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_number;
    logic                r_counter_rst;

    logic                w_filter_xfer;
    logic                w_data_xfer;
    logic [c_LANE_W-1:0] w_lane_inc;
    logic [CNT_W-1:0]    w_win_inc;

    assign w_filter_xfer = (r_state == c_S_LOAD) && filter_valid;
    assign w_data_xfer   = (r_state == c_S_MAC) && data_valid;
    assign w_lane_inc    = r_lane + c_LANE_W'(1);
    assign w_win_inc     = r_win + CNT_W'(1);

    assign mux_sel     = r_tap;
    assign ofm_addr    = r_addr;
    assign number      = r_number;
    assign counter_rst = r_counter_rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        filter_ready    = 1'b0;
        data_ready      = 1'b0;
        kernelFilter_en = '0;
        mac_en          = 1'b0;
        mac_rst         = 1'b0;
        shiftReg_en     = 1'b0;
        counter_en      = 1'b0;
        ofm_we          = 1'b0;
        done            = 1'b0;
        busy            = (r_state != c_S_IDLE);
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_next = (num_windows == '0) ? c_S_DONE : c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                filter_ready = 1'b1;
                if (w_filter_xfer) begin
                    // Each kernel word carries four taps, one nibble of enables.
                    kernelFilter_en = TAPS'(4'hF) << {r_k, 2'b00};
                    if (r_k == c_K_W'(c_WORDS - 1)) begin
                        w_state_next = c_S_CLEAR;
                    end
                end
            end
            c_S_CLEAR: begin
                mac_rst      = 1'b1;
                w_state_next = c_S_MAC;
            end
            c_S_MAC: begin
                data_ready = 1'b1;
                mac_en     = w_data_xfer;
                if (w_data_xfer && (r_tap == 4'(TAPS - 1))) begin
                    w_state_next = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                shiftReg_en = 1'b1;
                counter_en  = 1'b1;
                if ((w_lane_inc == c_LANE_W'(LANES_PER_WORD)) || (w_win_inc == r_num)) begin
                    w_state_next = c_S_WRITE;
                end else begin
                    w_state_next = c_S_CLEAR;
                end
            end
            c_S_WRITE: begin
                ofm_we       = 1'b1;
                w_state_next = (r_win == r_num) ? c_S_DONE : c_S_CLEAR;
            end
            c_S_DONE: begin
                done         = 1'b1;
                w_state_next = c_S_IDLE;
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k           <= '0;
            r_tap         <= '0;
            r_lane        <= '0;
            r_num         <= '0;
            r_win         <= '0;
            r_addr        <= '0;
            r_number      <= '0;
            r_counter_rst <= 1'b0;
        end else begin
            r_counter_rst <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_num         <= num_windows;
                        r_addr        <= ofm_base;
                        r_number      <= '0;
                        r_k           <= '0;
                        r_win         <= '0;
                        r_lane        <= '0;
                        r_counter_rst <= (num_windows != '0);
                    end
                end
                c_S_LOAD: begin
                    if (w_filter_xfer) begin
                        r_k <= r_k + c_K_W'(1);
                    end
                end
                c_S_CLEAR: begin
                    r_tap <= '0;
                end
                c_S_MAC: begin
                    // Wraps back to zero after the final tap.
                    if (w_data_xfer) begin
                        r_tap <= r_tap + 4'd1;
                    end
                end
                c_S_SHIFT: begin
                    r_lane <= w_lane_inc;
                    r_win  <= w_win_inc;
                end
                c_S_WRITE: begin
                    r_addr        <= r_addr + ADDR_W'(1);
                    r_number      <= r_number + 32'd1;
                    r_lane        <= '0;
                    r_counter_rst <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe2_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_pe2_controller                                            |
// | Purpose : Directed self-checking bench for pe2_controller.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_pe2_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_windows = '0;
    logic [31:0] ofm_base = '0;
    logic        filter_valid = 1'b0;
    logic        filter_ready;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [15:0] kernelFilter_en;
    logic [3:0]  mux_sel;
    logic        mac_en, mac_rst, shiftReg_en, counter_rst, counter_en;
    logic        ofm_we, done, busy;
    logic [31:0] ofm_addr;
    logic [31:0] number;

    int total = 0;
    int bad   = 0;

    pe2_controller dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_windows     (num_windows),
        .ofm_base        (ofm_base),
        .filter_valid    (filter_valid),
        .filter_ready    (filter_ready),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .kernelFilter_en (kernelFilter_en),
        .mux_sel         (mux_sel),
        .mac_en          (mac_en),
        .mac_rst         (mac_rst),
        .shiftReg_en     (shiftReg_en),
        .counter_rst     (counter_rst),
        .counter_en      (counter_en),
        .ofm_we          (ofm_we),
        .ofm_addr        (ofm_addr),
        .number          (number),
        .done            (done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    wire [29:0] w_all_ctl = {filter_ready, data_ready, kernelFilter_en, mux_sel, mac_en, mac_rst,
                             shiftReg_en, counter_rst, counter_en, ofm_we, done, busy};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        step();
        step();
        total++;
        if (w_all_ctl !== 30'd0) begin bad++; $display("FAIL reset_ctl got=%h exp=0", w_all_ctl); end
        total++;
        if (ofm_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", ofm_addr); end
        total++;
        if (number !== 32'd0) begin bad++; $display("FAIL reset_number got=%0d exp=0", number); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_four_windows();
        int n_mac = 0;
        logic [15:0] exp_kf;
        num_windows = 16'd4; ofm_base = 32'h100; filter_valid = 1'b1; data_valid = 1'b1;
        for (int c = 0; c <= 80; c++) begin
            start = (c == 0);
            #1;
            exp_kf = (c >= 1 && c <= 4) ? (16'h000F << (4 * (c - 1))) : 16'h0000;
            total++;
            if (kernelFilter_en !== exp_kf) begin bad++; $display("FAIL nom_kf c=%0d got=%h exp=%h", c, kernelFilter_en, exp_kf); end
            total++;
            if (mac_rst !== (c == 5 || c == 23 || c == 41 || c == 59)) begin bad++; $display("FAIL nom_mac_rst c=%0d got=%b", c, mac_rst); end
            total++;
            if (shiftReg_en !== (c == 22 || c == 40 || c == 58 || c == 76)) begin bad++; $display("FAIL nom_shift c=%0d got=%b", c, shiftReg_en); end
            total++;
            if (ofm_we !== (c == 77)) begin bad++; $display("FAIL nom_we c=%0d got=%b", c, ofm_we); end
            total++;
            if (done !== (c == 78)) begin bad++; $display("FAIL nom_done c=%0d got=%b", c, done); end
            total++;
            if (counter_rst !== (c == 1 || c == 78)) begin bad++; $display("FAIL nom_cnt_rst c=%0d got=%b", c, counter_rst); end
            if (c == 77) begin
                total++;
                if (ofm_addr !== 32'h100) begin bad++; $display("FAIL nom_addr got=%h exp=100", ofm_addr); end
            end
            if (c == 10) begin
                total++;
                if (mux_sel !== 4'd4) begin bad++; $display("FAIL nom_mux got=%0d exp=4", mux_sel); end
            end
            if (mac_en === 1'b1) n_mac++;
            step();
        end
        total++;
        if (n_mac != 64) begin bad++; $display("FAIL nom_mac_count got=%0d exp=64", n_mac); end
        total++;
        if (number !== 32'd1) begin bad++; $display("FAIL nom_number got=%0d exp=1", number); end
        total++;
        if (ofm_addr !== 32'h101) begin bad++; $display("FAIL nom_addr_after got=%h exp=101", ofm_addr); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL nom_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_partial_word();
        num_windows = 16'd6; ofm_base = 32'h0; filter_valid = 1'b1; data_valid = 1'b1;
        for (int c = 0; c <= 117; c++) begin
            start = (c == 0);
            #1;
            total++;
            if (ofm_we !== (c == 77 || c == 114)) begin bad++; $display("FAIL part_we c=%0d got=%b", c, ofm_we); end
            total++;
            if (done !== (c == 115)) begin bad++; $display("FAIL part_done c=%0d got=%b", c, done); end
            if (c == 77 || c == 114) begin
                total++;
                if (ofm_addr !== ((c == 77) ? 32'd0 : 32'd1)) begin bad++; $display("FAIL part_addr c=%0d got=%h", c, ofm_addr); end
            end
            step();
        end
        total++;
        if (number !== 32'd2) begin bad++; $display("FAIL part_number got=%0d exp=2", number); end
        total++;
        if (ofm_addr !== 32'd2) begin bad++; $display("FAIL part_addr_after got=%h exp=2", ofm_addr); end
    endtask

    task automatic test_mac_stall();
        int n_mac = 0;
        num_windows = 16'd1; ofm_base = 32'h20; filter_valid = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            start = (c == 0);
            data_valid = !(c >= 13 && c <= 15);
            #1;
            if (c >= 13 && c <= 15) begin
                total++;
                if (mac_en !== 1'b0) begin bad++; $display("FAIL stall_mac_en c=%0d got=%b exp=0", c, mac_en); end
                total++;
                if (mux_sel !== 4'd7) begin bad++; $display("FAIL stall_mux c=%0d got=%0d exp=7", c, mux_sel); end
            end
            if (c == 16) begin
                total++;
                if ({mac_en, mux_sel} !== {1'b1, 4'd7}) begin bad++; $display("FAIL stall_resume got=%b/%0d exp=1/7", mac_en, mux_sel); end
            end
            total++;
            if (shiftReg_en !== (c == 25)) begin bad++; $display("FAIL stall_shift c=%0d got=%b", c, shiftReg_en); end
            total++;
            if (done !== (c == 27)) begin bad++; $display("FAIL stall_done c=%0d got=%b", c, done); end
            if (mac_en === 1'b1) n_mac++;
            step();
        end
        data_valid = 1'b1;
        total++;
        if (n_mac != 16) begin bad++; $display("FAIL stall_mac_count got=%0d exp=16", n_mac); end
    endtask

    task automatic test_filter_stall();
        logic [15:0] exp_kf;
        num_windows = 16'd1; ofm_base = 32'h0; data_valid = 1'b1;
        for (int c = 0; c <= 28; c++) begin
            start = (c == 0);
            filter_valid = !(c == 2 || c == 3);
            #1;
            case (c)
                1:       exp_kf = 16'h000F;
                4:       exp_kf = 16'h00F0;
                5:       exp_kf = 16'h0F00;
                6:       exp_kf = 16'hF000;
                default: exp_kf = 16'h0000;
            endcase
            total++;
            if (kernelFilter_en !== exp_kf) begin bad++; $display("FAIL fstall_kf c=%0d got=%h exp=%h", c, kernelFilter_en, exp_kf); end
            total++;
            if (filter_ready !== (c >= 1 && c <= 6)) begin bad++; $display("FAIL fstall_ready c=%0d got=%b", c, filter_ready); end
            total++;
            if (mac_rst !== (c == 7)) begin bad++; $display("FAIL fstall_mac_rst c=%0d got=%b", c, mac_rst); end
            total++;
            if (done !== (c == 26)) begin bad++; $display("FAIL fstall_done c=%0d got=%b", c, done); end
            step();
        end
        filter_valid = 1'b1;
    endtask

    task automatic test_zero_and_busy();
        num_windows = 16'd0; ofm_base = 32'h0; filter_valid = 1'b1; data_valid = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            start = (c == 0);
            #1;
            total++;
            if (done !== (c == 1)) begin bad++; $display("FAIL zero_done c=%0d got=%b", c, done); end
            total++;
            if ({kernelFilter_en, mac_en, ofm_we} !== 18'd0) begin bad++; $display("FAIL zero_activity c=%0d got=%h exp=0", c, {kernelFilter_en, mac_en, ofm_we}); end
            step();
        end
        for (int c = 0; c <= 27; c++) begin
            start = (c == 0 || c == 10);
            if (c == 0) begin num_windows = 16'd1; ofm_base = 32'h40; end
            if (c == 10) begin num_windows = 16'd5; ofm_base = 32'h999; end
            #1;
            total++;
            if (ofm_we !== (c == 23)) begin bad++; $display("FAIL busy_we c=%0d got=%b", c, ofm_we); end
            total++;
            if (done !== (c == 24)) begin bad++; $display("FAIL busy_done c=%0d got=%b", c, done); end
            if (c == 23) begin
                total++;
                if (ofm_addr !== 32'h40) begin bad++; $display("FAIL busy_addr got=%h exp=40", ofm_addr); end
            end
            step();
        end
        total++;
        if (number !== 32'd1) begin bad++; $display("FAIL busy_number got=%0d exp=1", number); end
        total++;
        if (ofm_addr !== 32'h41) begin bad++; $display("FAIL busy_addr_after got=%h exp=41", ofm_addr); end
    endtask

    task automatic test_reset_mid();
        num_windows = 16'd4; ofm_base = 32'h300; filter_valid = 1'b1; data_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            start = (c == 0);
            step();
        end
        total++;
        if (data_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_mac got=%b exp=1", data_ready); end
        rst = 1'b0;
        #1;
        total++;
        if (w_all_ctl !== 30'd0) begin bad++; $display("FAIL rmid_ctl got=%h exp=0", w_all_ctl); end
        total++;
        if ({ofm_addr, number} !== 64'd0) begin bad++; $display("FAIL rmid_regs got=%h/%h exp=0/0", ofm_addr, number); end
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if ({ofm_we, busy} !== 2'b00) begin bad++; $display("FAIL rmid_hold c=%0d got=%b exp=00", c, {ofm_we, busy}); end
        end
        rst = 1'b1;
        step();
        num_windows = 16'd1; ofm_base = 32'h500;
        for (int c = 0; c <= 25; c++) begin
            start = (c == 0);
            #1;
            total++;
            if (ofm_we !== (c == 23)) begin bad++; $display("FAIL rfresh_we c=%0d got=%b", c, ofm_we); end
            total++;
            if (done !== (c == 24)) begin bad++; $display("FAIL rfresh_done c=%0d got=%b", c, done); end
            step();
        end
        total++;
        if ({number, ofm_addr} !== {32'd1, 32'h501}) begin bad++; $display("FAIL rfresh_regs got=%0d/%h exp=1/501", number, ofm_addr); end
    endtask

    initial begin
        test_reset();
        test_four_windows();
        test_partial_word();
        test_mac_stall();
        test_filter_stall();
        test_zero_and_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe2_controller.md
Name: pe2_controller

Overview:
- Sequencer for the four-lane convolution processing element (PE2).
- Loads the 16-tap kernel into each lane's filter buffer and steps the 16:1 tap mux while MAC inputs stream in.
- Packs four 8-bit window results into the 32-bit shift register, writes each packed word to the output feature map (OFM), and pulses done at end of job.
- Sits between the top-level job control / input buffers and PE2's control pins.

Parameters:
- TAPS, 16: kernel taps per window; sets mux_sel range and MAC cycles per window.
- LANES_PER_WORD, 4: window results packed per OFM word.
- ADDR_W, 32: OFM address width.
- CNT_W, 16: width of the window count.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  job start, sampled in IDLE only
- num_windows  in  CNT_W  windows in job, sampled with start
- ofm_base  in  ADDR_W  first OFM word address, sampled with start
- filter_valid  in  1  kernel word (4 taps) present on PE2 bufferInput1..4
- filter_ready  out  1  controller accepts kernel word this cycle
- data_valid  in  1  tap operands present on PE2 mac2_input1..4
- data_ready  out  1  controller consumes tap operands this cycle
- kernelFilter_en  out  16  per-tap filter buffer write enables
- mux_sel  out  4  tap select
- mac_en  out  1  MAC accumulate enable
- mac_rst  out  1  MAC accumulator clear
- shiftReg_en  out  1  shift register capture
- counter_rst  out  1  PE2 lane counter reset
- counter_en  out  1  PE2 lane counter increment
- ofm_we  out  1  OFM write strobe
- ofm_addr  out  ADDR_W  OFM write address
- number  out  32  OFM words written in current job
- done  out  1  one-cycle end-of-job pulse
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all strobes/enables=0, mux_sel=0, ofm_addr=0, number=0, internal counters=0. Reset mid-job aborts with no further writes.
- Handshakes:
  - A transfer occurs when valid & ready are both high.
  - filter_ready=1 only in LOAD; data_ready=1 only in MAC.
  - Ready does not depend combinationally on valid.
- IDLE: on start=1, latch num_windows, ofm_base (into ofm_addr), clear number and load index.
  - num_windows=0: go to DONE.
  - Otherwise: go to LOAD with counter_rst=1 for that cycle.
  - start while busy=1 is ignored.
- LOAD: load index k=0..3.
  - On each transfer, kernelFilter_en[4k+3:4k]=4'hF (combinational with the transfer), else 0.
  - After 4th transfer, go to CLEAR.
  - No transfer leaves state and k unchanged.
- CLEAR: mac_rst=1 for one cycle, tap counter=0, then go to MAC.
- MAC:
  - mux_sel=tap counter.
  - mac_en = data_valid & data_ready.
  - On each transfer, tap counter increments.
  - On transfer with tap = TAPS-1, go to SHIFT.
  - data_valid=0 stalls: mac_en=0, mux_sel held.
- SHIFT: shiftReg_en=1 and counter_en=1 for one cycle; lane counter++, window counter++.
  - If lane counter reaches LANES_PER_WORD, or this was the last window: go to WRITE.
  - Else: go to CLEAR.
- WRITE: ofm_we=1 for one cycle at current ofm_addr.
  - Next cycle: ofm_addr+1 (wraps at 2^ADDR_W), number+1, lane counter=0, counter_rst=1.
  - Windows remaining: go to CLEAR. Else: go to DONE.
  - A partial final word (fewer than 4 lanes) is still written; stale upper bytes are don't-care.
- DONE: done=1 for one cycle, then go to IDLE. number and ofm_addr hold until next start.
- Timing, no stalls: 4 LOAD cycles; 18 cycles per window (CLEAR + 16 MAC + SHIFT); +1 cycle per WRITE.
- Outputs are registered or decoded from state only; there are no combinational paths from data inputs except the ready/valid-qualified enables (kernelFilter_en, mac_en).

Test Plan:
- num_windows=4, ofm_base=0x100, valids held high, start in cycle 0 → LOAD cycles 1-4 with kernelFilter_en 0x000F, 0x00F0, 0x0F00, 0xF000; mac_rst at 5, 23, 41, 59; shiftReg_en at 22, 40, 58, 76; single ofm_we at 77 with addr 0x100; done at 78; number=1.
- num_windows=6, ofm_base=0 → ofm_we at addr 0 after window 4 and addr 1 after window 6 (partial word); number=2; ofm_addr=2 after done.
- data_valid deasserted 3 cycles at tap 7 → mac_en=0 and mux_sel=7 held during stall; window completes 3 cycles late; exactly 16 mac_en pulses per window.
- filter_valid low for 2 cycles between words 1 and 2 → kernelFilter_en stays 0 while low; LOAD extends by 2 cycles.
- num_windows=0 → done at cycle 1, no kernelFilter_en/mac_en/ofm_we activity. Second start while busy → ignored.
- rst pulsed low mid-MAC of window 2 → all outputs 0 immediately, state IDLE, no ofm_we; a fresh start afterwards runs the full sequence correctly.
